// File: rtl/pp_csa_pipe.sv
// pp_csa_pipe: three-stage carry-save reduction of 13 radix-4 Booth partial
// products into a 48-bit mantissa product, with a pass-through tag and
// valid/ready handshakes on both sides.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i / ready_o       upstream handshake (ready_o is combinational from ready_i)
//   pp_00_i .. pp_12_i      W-bit two's complement partial products, pre-shifted
//   tag_i                   side-band bundle carried with each operand set
//   valid_o / ready_i       downstream handshake
//   product_o               (sum of all pp) mod 2^W, low P bits
//   tag_o                   tag aligned with product_o
//
// Stages: S1 = CSA 13->9->6, S2 = CSA 6->4->3->2, S3 = W-bit CPA.
// All arithmetic is mod 2^W; carries shifted past bit W-1 are dropped.
module pp_csa_pipe #(
  parameter int PARM_MANT = 23,
  parameter int PARM_TAG  = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [2*PARM_MANT+2:0]  pp_00_i,
  input  logic [2*PARM_MANT+2:0]  pp_01_i,
  input  logic [2*PARM_MANT+2:0]  pp_02_i,
  input  logic [2*PARM_MANT+2:0]  pp_03_i,
  input  logic [2*PARM_MANT+2:0]  pp_04_i,
  input  logic [2*PARM_MANT+2:0]  pp_05_i,
  input  logic [2*PARM_MANT+2:0]  pp_06_i,
  input  logic [2*PARM_MANT+2:0]  pp_07_i,
  input  logic [2*PARM_MANT+2:0]  pp_08_i,
  input  logic [2*PARM_MANT+2:0]  pp_09_i,
  input  logic [2*PARM_MANT+2:0]  pp_10_i,
  input  logic [2*PARM_MANT+2:0]  pp_11_i,
  input  logic [2*PARM_MANT+2:0]  pp_12_i,
  input  logic [PARM_TAG-1:0]     tag_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [2*PARM_MANT+1:0]  product_o,
  output logic [PARM_TAG-1:0]     tag_o
);

  localparam int W = 2*PARM_MANT + 3;
  localparam int P = 2*PARM_MANT + 2;

  typedef logic [W-1:0] vec_t;

  function automatic vec_t csa_sum(input vec_t a, input vec_t b, input vec_t c);
    return a ^ b ^ c;
  endfunction

  // Majority shifted left by one; the bit leaving position W-1 is discarded.
  function automatic vec_t csa_carry(input vec_t a, input vec_t b, input vec_t c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake chain: a stage loads when empty or when the stage after it loads.
  // ---------------------------------------------------------------------------
  logic v1, v2, v3;
  logic load1, load2, load3;

  assign load3   = ~v3 | ready_i;
  assign load2   = ~v2 | load3;
  assign load1   = ~v1 | load2;
  assign ready_o = load1;
  assign valid_o = v3;

  // ---------------------------------------------------------------------------
  // S1 combinational: 13 -> 9 -> 6
  // ---------------------------------------------------------------------------
  vec_t pp [13];
  vec_t l1 [9];
  vec_t l2 [6];

  assign pp[0]  = pp_00_i;
  assign pp[1]  = pp_01_i;
  assign pp[2]  = pp_02_i;
  assign pp[3]  = pp_03_i;
  assign pp[4]  = pp_04_i;
  assign pp[5]  = pp_05_i;
  assign pp[6]  = pp_06_i;
  assign pp[7]  = pp_07_i;
  assign pp[8]  = pp_08_i;
  assign pp[9]  = pp_09_i;
  assign pp[10] = pp_10_i;
  assign pp[11] = pp_11_i;
  assign pp[12] = pp_12_i;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      l1[2*i]   = csa_sum  (pp[3*i], pp[3*i+1], pp[3*i+2]);
      l1[2*i+1] = csa_carry(pp[3*i], pp[3*i+1], pp[3*i+2]);
    end
    l1[8] = pp[12];
    for (int unsigned i = 0; i < 3; i++) begin
      l2[2*i]   = csa_sum  (l1[3*i], l1[3*i+1], l1[3*i+2]);
      l2[2*i+1] = csa_carry(l1[3*i], l1[3*i+1], l1[3*i+2]);
    end
  end

  vec_t                r1 [6];
  logic [PARM_TAG-1:0] t1;

  always_ff @(posedge clk_i) begin
    if (load1 && valid_i) begin
      for (int unsigned i = 0; i < 6; i++) r1[i] <= l2[i];
      t1 <= tag_i;
    end
  end

  // ---------------------------------------------------------------------------
  // S2 combinational: 6 -> 4 -> 3 -> 2
  // ---------------------------------------------------------------------------
  vec_t l3 [4];
  vec_t l4 [3];
  vec_t l5_sum, l5_carry;

  always_comb begin
    l3[0]    = csa_sum  (r1[0], r1[1], r1[2]);
    l3[1]    = csa_carry(r1[0], r1[1], r1[2]);
    l3[2]    = csa_sum  (r1[3], r1[4], r1[5]);
    l3[3]    = csa_carry(r1[3], r1[4], r1[5]);
    l4[0]    = csa_sum  (l3[0], l3[1], l3[2]);
    l4[1]    = csa_carry(l3[0], l3[1], l3[2]);
    l4[2]    = l3[3];
    l5_sum   = csa_sum  (l4[0], l4[1], l4[2]);
    l5_carry = csa_carry(l4[0], l4[1], l4[2]);
  end

  vec_t                r2_sum, r2_carry;
  logic [PARM_TAG-1:0] t2;

  always_ff @(posedge clk_i) begin
    if (load2 && v1) begin
      r2_sum   <= l5_sum;
      r2_carry <= l5_carry;
      t2       <= t1;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: carry-propagate add; only the low P bits are presented.
  // ---------------------------------------------------------------------------
  vec_t cpa;
  logic cpa_unused_msb;

  assign cpa            = r2_sum + r2_carry;
  assign cpa_unused_msb = cpa[W-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      product_o <= '0;
      tag_o     <= '0;
    end else begin
      if (load1) v1 <= valid_i;
      if (load2) v2 <= v1;
      if (load3) begin
        v3 <= v2;
        if (v2) begin
          product_o <= cpa[P-1:0];
          tag_o     <= t2;
        end
      end
    end
  end

endmodule
